// File: rtl/cr_axi4s_mstr_arb.sv
// cr_axi4s_mstr_arb
// Packet-locked round-robin arbiter that drains N_CH show-ahead FIFOs into
// one AXI4-Stream master port. A grant is held for a whole packet (until the
// beat carrying tlast is popped). Popped beats pass through a 2-entry output
// buffer, so the pop strobe does not depend on ob_tready and the port can
// still move one beat per clock.
module cr_axi4s_mstr_arb #(
  parameter int N_CH      = 4,
  parameter int DATA_W    = 64,
  parameter int USER_W    = 8,
  parameter int MAX_BEATS = 256,
  localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_CH-1:0]          in_empty,
  input  logic [N_CH*DATA_W-1:0]   in_data,
  input  logic [N_CH-1:0]          in_last,
  input  logic [N_CH*USER_W-1:0]   in_user,
  output logic [N_CH-1:0]          in_rd,
  output logic                     ob_tvalid,
  input  logic                     ob_tready,
  output logic [DATA_W-1:0]        ob_tdata,
  output logic                     ob_tlast,
  output logic [USER_W-1:0]        ob_tuser,
  output logic [CH_W-1:0]          ob_tid,
  output logic                     busy,
  output logic                     err_oversize,
  input  logic                     err_clr
);

  // One extra bit beyond what MAX_BEATS+1 needs, so the overflow count is
  // representable.
  localparam int              BC_W     = $clog2(MAX_BEATS + 1) + 1;
  localparam logic [BC_W-1:0] OVER_CNT = BC_W'(MAX_BEATS + 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
    logic [USER_W-1:0] user;
    logic [CH_W-1:0]   id;
  } entry_t;

  state_t          state, state_nxt;
  logic [CH_W-1:0] grant, grant_nxt;
  logic [CH_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [CH_W-1:0] rr_pick, pick_hi, pick_lo;
  logic            hi_any, lo_any;
  logic [N_CH-1:0] req;

  logic [1:0]      occ;
  entry_t          ent0, ent1, pop_ent;
  logic            pop, accept;

  logic [BC_W-1:0] beat_cnt, cnt_inc;
  logic            err_set;

  // Round-robin pick: the lowest requester above rr_ptr, else the lowest
  // requester overall.
  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    req     = ~in_empty;
    hi_any  = 1'b0;
    lo_any  = 1'b0;
    pick_hi = '0;
    pick_lo = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_any  = 1'b1;
        pick_lo = CH_W'(i);
        if (i > int'(rr_ptr)) begin
          hi_any  = 1'b1;
          pick_hi = CH_W'(i);
        end
      end
    end
    rr_pick = hi_any ? pick_hi : pick_lo;
  end

  // Pop strobe: only the granted channel, and only while the buffer has room.
  always_comb begin
    in_rd = '0;
    pop   = 1'b0;
    if (state == ST_XFER && !in_empty[grant] && occ != 2'd2) begin
      pop          = 1'b1;
      in_rd[grant] = 1'b1;
    end
  end

  // Head word of the granted channel, packed as a buffer entry.
  always_comb begin
    pop_ent.data = in_data[int'(grant)*DATA_W +: DATA_W];
    pop_ent.last = in_last[grant];
    pop_ent.user = in_user[int'(grant)*USER_W +: USER_W];
    pop_ent.id   = grant;
  end

  // Grant FSM next state: lock onto a channel, release on the tlast pop.
  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant;
    rr_ptr_nxt = rr_ptr;
    case (state)
      ST_IDLE: begin
        if (lo_any) begin
          grant_nxt = rr_pick;
          state_nxt = ST_XFER;
        end
      end
      ST_XFER: begin
        if (pop && pop_ent.last) begin
          state_nxt  = ST_IDLE;
          rr_ptr_nxt = grant;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Grant FSM registers; rr_ptr starts at the last channel so channel 0 wins
  // the first arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before this edge.
    if (!rst_n) begin
      state  <= ST_IDLE;
      grant  <= '0;
      rr_ptr <= CH_W'(N_CH - 1);
    end else begin
      state  <= state_nxt;
      grant  <= grant_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

  assign accept = ob_tvalid && ob_tready;

  // Two-entry output buffer; ent0 is always the oldest beat and drives ob_*.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the buffer entries are reset because they drive ob_* directly and
    // those outputs must read zero while in reset.
    if (!rst_n) begin
      occ  <= 2'd0;
      ent0 <= '0;
      ent1 <= '0;
    end else begin
      case ({pop, accept})
        2'b10: begin
          if (occ == 2'd0) ent0 <= pop_ent;
          else             ent1 <= pop_ent;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          if (occ == 2'd2) ent0 <= ent1;
          occ <= occ - 2'd1;
        end
        2'b11: begin
          // Only reachable with occ == 1: the new beat replaces the departing head.
          ent0 <= pop_ent;
        end
        default: ;
      endcase
    end
  end

  assign ob_tvalid = (occ != 2'd0);
  assign ob_tdata  = ent0.data;
  assign ob_tlast  = ent0.last;
  assign ob_tuser  = ent0.user;
  assign ob_tid    = ent0.id;
  assign busy      = (state == ST_XFER) || (occ != 2'd0);

  assign cnt_inc = beat_cnt + 1'b1;
  assign err_set = pop && (cnt_inc == OVER_CNT);

  // Beats-per-packet counter; saturates at MAX_BEATS+1 so an endless packet
  // cannot wrap it around.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
    end else if (pop) begin
      if (pop_ent.last)            beat_cnt <= '0;
      else if (beat_cnt != OVER_CNT) beat_cnt <= cnt_inc;
    end
  end

  // Sticky oversize flag; a set event in the same cycle beats err_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err_oversize <= 1'b0;
    else if (err_set) err_oversize <= 1'b1;
    else if (err_clr) err_oversize <= 1'b0;
  end

endmodule

// File: tb/tb_cr_axi4s_mstr_arb.sv
// tb_cr_axi4s_mstr_arb
// Self-checking bench: source FIFOs are modelled as queues, a packet-level
// round-robin model predicts the output beat order, and a monitor compares
// every accepted beat, the AXI hold rule, pop legality and the oversize flag.
module tb_cr_axi4s_mstr_arb;

  localparam int N_CH      = 4;
  localparam int DATA_W    = 64;
  localparam int USER_W    = 8;
  localparam int MAX_BEATS = 4;
  localparam int CH_W      = 2;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
    logic [USER_W-1:0] user;
    logic [CH_W-1:0]   id;
  } beat_t;

  logic                   clk;
  logic                   rst_n;
  logic [N_CH-1:0]        in_empty;
  logic [N_CH*DATA_W-1:0] in_data;
  logic [N_CH-1:0]        in_last;
  logic [N_CH*USER_W-1:0] in_user;
  logic [N_CH-1:0]        in_rd;
  logic                   ob_tvalid;
  logic                   ob_tready;
  logic [DATA_W-1:0]      ob_tdata;
  logic                   ob_tlast;
  logic [USER_W-1:0]      ob_tuser;
  logic [CH_W-1:0]        ob_tid;
  logic                   busy;
  logic                   err_oversize;
  logic                   err_clr;

  cr_axi4s_mstr_arb #(
    .N_CH(N_CH), .DATA_W(DATA_W), .USER_W(USER_W), .MAX_BEATS(MAX_BEATS)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_empty(in_empty), .in_data(in_data), .in_last(in_last), .in_user(in_user),
    .in_rd(in_rd),
    .ob_tvalid(ob_tvalid), .ob_tready(ob_tready), .ob_tdata(ob_tdata),
    .ob_tlast(ob_tlast), .ob_tuser(ob_tuser), .ob_tid(ob_tid),
    .busy(busy), .err_oversize(err_oversize), .err_clr(err_clr)
  );

  // Bench state
  beat_t           src_q[N_CH][$];    // contents visible to the DUT
  beat_t           stage_q[N_CH][$];  // created but not yet written to a FIFO
  beat_t           pend_q[N_CH][$];   // not yet placed in the predicted order
  beat_t           exp_q[$];          // predicted output order
  int              pop_cyc_q[$];
  int              acc_cyc_q[$];
  logic [CH_W-1:0] acc_tid_q[$];
  int              checks, failures;
  int              cyc;
  int              model_last;
  int              ready_mode, ready_ph;
  logic [N_CH-1:0] rd_s;
  int              pkt_cnt;
  logic            err_exp;
  logic            hold_prev;
  beat_t           prev_beat;
  int              stall_cnt, err_hi_cnt;
  int              t0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req_v, $time);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic refresh_inputs();
    for (int i = 0; i < N_CH; i++) begin
      in_empty[i] = (src_q[i].size() == 0);
      if (src_q[i].size() != 0) begin
        in_data[i*DATA_W +: DATA_W] = src_q[i][0].data;
        in_last[i]                  = src_q[i][0].last;
        in_user[i*USER_W +: USER_W] = src_q[i][0].user;
      end else begin
        in_data[i*DATA_W +: DATA_W] = '0;
        in_last[i]                  = 1'b0;
        in_user[i*USER_W +: USER_W] = '0;
      end
    end
  endtask

  // Source FIFO and ready driver, 1 time unit after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (rst_n) begin
        for (int i = 0; i < N_CH; i++)
          if (rd_s[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
      end
      case (ready_mode)
        0: ob_tready = 1'b1;
        1: begin
          ob_tready = (ready_ph % 4 == 0) || (ready_ph % 4 == 3);
          ready_ph++;
        end
        2: ob_tready = 1'($urandom_range(0, 1));
        default: ob_tready = 1'b0;
      endcase
      refresh_inputs();
    end
  end

  // Monitor and scoreboard on the falling edge.
  always @(negedge clk) begin
    beat_t cur, e;
    int    ch;
    logic  set;
    if (rst_n) begin
      cur = {ob_tdata, ob_tlast, ob_tuser, ob_tid};
      check("in_rd_onehot0", 128'($onehot0(in_rd)), 1);
      if (hold_prev) begin
        check("hold_valid", ob_tvalid, 1);
        check("hold_beat", cur, prev_beat);
      end
      if (ob_tvalid && ob_tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", cur, 0);
          failures += (cur == '0) ? 1 : 0;
        end else begin
          e = exp_q.pop_front();
          check("beat", cur, e);
        end
        if (pop_cyc_q.size() != 0) begin
          ch = pop_cyc_q.pop_front();
          if (ready_mode == 0) check("latency", cyc, ch + 1);
        end
        acc_cyc_q.push_back(cyc);
        acc_tid_q.push_back(ob_tid);
      end
      if (ob_tvalid && in_rd == '0 && src_q[ob_tid].size() != 0) stall_cnt++;
      check("err_oversize", err_oversize, err_exp);
      if (err_oversize) err_hi_cnt++;
      set = 1'b0;
      if (in_rd != '0) begin
        ch = 0;
        for (int i = 0; i < N_CH; i++) if (in_rd[i]) ch = i;
        check("rd_nonempty", 128'(src_q[ch].size() != 0), 1);
        if (src_q[ch].size() != 0) begin
          e = src_q[ch][0];
          pkt_cnt++;
          set = (pkt_cnt == MAX_BEATS + 1);
          if (e.last) pkt_cnt = 0;
          pop_cyc_q.push_back(cyc);
        end
      end
      if (set)          err_exp = 1'b1;
      else if (err_clr) err_exp = 1'b0;
      hold_prev = ob_tvalid && !ob_tready;
      prev_beat = cur;
      rd_s      = in_rd;
    end else begin
      rd_s = '0;
    end
  end

  // Stimulus helpers
  task automatic add_packet(input int ch, input int len);
    beat_t w;
    for (int b = 0; b < len; b++) begin
      w.data = {$urandom, $urandom};
      w.last = (b == len - 1);
      w.user = USER_W'($urandom);
      w.id   = CH_W'(ch);
      pend_q[ch].push_back(w);
      stage_q[ch].push_back(w);
    end
  endtask

  task automatic release_beats(input int ch, input int n);
    for (int k = 0; k < n && stage_q[ch].size() != 0; k++)
      src_q[ch].push_back(stage_q[ch].pop_front());
    refresh_inputs();
  endtask

  task automatic release_all();
    for (int c = 0; c < N_CH; c++) release_beats(c, stage_q[c].size());
  endtask

  // Packet-level round robin: next channel after the last served one that has
  // a packet waiting; its whole packet goes out before anything else.
  task automatic model_arbitrate();
    beat_t b;
    int    c;
    bit    found;
    forever begin
      found = 0;
      c     = 0;
      for (int k = 1; k <= N_CH && !found; k++) begin
        c = (model_last + k) % N_CH;
        if (pend_q[c].size() != 0) found = 1;
      end
      if (!found) break;
      do begin
        b = pend_q[c].pop_front();
        exp_q.push_back(b);
      end while (!b.last);
      model_last = c;
    end
  endtask

  function automatic bit idle_now();
    bit r;
    r = (exp_q.size() == 0) && !busy;
    for (int c = 0; c < N_CH; c++)
      if (src_q[c].size() != 0 || stage_q[c].size() != 0) r = 0;
    return r;
  endfunction

  task automatic wait_drain(input int budget, input string name);
    int n;
    bit done;
    n    = 0;
    done = 0;
    while (!done && n < budget) begin
      @(posedge clk);
      #3;
      n++;
      done = idle_now();
    end
    check({name, "_drain"}, 128'(done), 1);
  endtask

  task automatic next_slot();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_stamps();
    acc_cyc_q.delete();
    acc_tid_q.delete();
  endtask

  task automatic pulse_err_clr();
    next_slot();
    err_clr = 1'b1;
    next_slot();
    err_clr = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0; cyc = 0;
    model_last = N_CH - 1; ready_mode = 0; ready_ph = 0;
    rd_s = '0; pkt_cnt = 0; err_exp = 1'b0; hold_prev = 1'b0; prev_beat = '0;
    stall_cnt = 0; err_hi_cnt = 0;
    rst_n = 1'b0; err_clr = 1'b0; ob_tready = 1'b0;
    in_empty = '1; in_data = '0; in_last = '0; in_user = '0;
    refresh_inputs();

    // Reset state
    #12;
    check("rst_tvalid", ob_tvalid, 0);
    check("rst_tdata", ob_tdata, 0);
    check("rst_tlast", ob_tlast, 0);
    check("rst_tuser", ob_tuser, 0);
    check("rst_tid", ob_tid, 0);
    check("rst_in_rd", in_rd, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_oversize, 0);
    next_slot();
    rst_n = 1'b1;
    next_slot();

    // Four 2-beat packets present at once, ready always high
    clear_stamps();
    for (int c = 0; c < N_CH; c++) add_packet(c, 2);
    release_all();
    t0 = cyc;
    model_arbitrate();
    check("busy_on_start", 128'(busy), 0);
    wait_drain(200, "rr4");
    check("rr4_count", acc_cyc_q.size(), 8);
    if (acc_cyc_q.size() == 8) begin
      check("rr4_first_latency", acc_cyc_q[0] - t0, 2);
      for (int p = 1; p < N_CH; p++) begin
        check("rr4_gap", acc_cyc_q[2*p] - acc_cyc_q[2*p-2], 3);
        check("rr4_tid", acc_tid_q[2*p], p);
      end
    end

    // 100-beat packet on channel 2: one beat per clock
    next_slot();
    clear_stamps();
    add_packet(2, 100);
    release_all();
    model_arbitrate();
    wait_drain(400, "long");
    check("long_count", acc_cyc_q.size(), 100);
    if (acc_cyc_q.size() == 100) check("long_back_to_back", acc_cyc_q[99] - acc_cyc_q[0], 99);
    check("long_err_set", err_oversize, 1);
    pulse_err_clr();
    #1;
    check("long_err_cleared", err_oversize, 0);

    // Backpressure pattern 1,0,0,1
    next_slot();
    clear_stamps();
    ready_mode = 1; ready_ph = 0; stall_cnt = 0;
    add_packet(1, 8);
    release_all();
    model_arbitrate();
    wait_drain(200, "bp");
    ready_mode = 0;
    check("bp_count", acc_cyc_q.size(), 8);
    check("bp_stalled", 128'(stall_cnt > 0), 1);
    pulse_err_clr();

    // One beat on channel 0, then channel 1 stalls mid-packet with 0 waiting
    next_slot();
    add_packet(0, 1);
    release_all();
    model_arbitrate();
    wait_drain(50, "single");
    next_slot();
    clear_stamps();
    add_packet(1, 5);
    add_packet(0, 2);
    release_beats(1, 3);
    release_beats(0, 2);
    model_arbitrate();
    repeat (15) next_slot();
    check("stall_busy", busy, 1);
    check("stall_in_rd", in_rd, 0);
    check("stall_drained", ob_tvalid, 0);
    release_beats(1, 2);
    wait_drain(100, "stall");
    check("stall_count", acc_tid_q.size(), 7);
    if (acc_tid_q.size() == 7) begin
      check("stall_tid_first", acc_tid_q[4], 1);
      check("stall_tid_next", acc_tid_q[5], 0);
    end
    pulse_err_clr();

    // Oversize: 6 beats with MAX_BEATS=4
    next_slot();
    clear_stamps();
    add_packet(2, 6);
    release_all();
    model_arbitrate();
    wait_drain(100, "over");
    check("over_count", acc_cyc_q.size(), 6);
    check("over_err", err_oversize, 1);
    pulse_err_clr();
    #1;
    check("over_err_clr", err_oversize, 0);

    // err_clr held high across the set event: set wins for one cycle
    next_slot();
    err_clr = 1'b1;
    err_hi_cnt = 0;
    add_packet(3, 5);
    release_all();
    model_arbitrate();
    wait_drain(100, "setwins");
    err_clr = 1'b0;
    check("setwins_cycles", err_hi_cnt, 1);

    // Random packets and random backpressure
    ready_mode = 2;
    for (int batch = 0; batch < 6; batch++) begin
      next_slot();
      for (int c = 0; c < N_CH; c++) begin
        int np;
        np = $urandom_range(0, 2);
        for (int p = 0; p < np; p++) add_packet(c, $urandom_range(1, 5));
      end
      release_all();
      model_arbitrate();
      wait_drain(600, "rand");
    end
    ready_mode = 0;

    // Reset mid-packet with the buffer full
    next_slot();
    ready_mode = 3;
    add_packet(3, 6);
    release_all();
    model_arbitrate();
    repeat (8) next_slot();
    check("pre_rst_valid", ob_tvalid, 1);
    check("pre_rst_busy", busy, 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_tvalid", ob_tvalid, 0);
    check("arst_tdata", ob_tdata, 0);
    check("arst_tlast", ob_tlast, 0);
    check("arst_tuser", ob_tuser, 0);
    check("arst_tid", ob_tid, 0);
    check("arst_in_rd", in_rd, 0);
    check("arst_busy", busy, 0);
    check("arst_err", err_oversize, 0);
    for (int c = 0; c < N_CH; c++) begin
      src_q[c].delete(); stage_q[c].delete(); pend_q[c].delete();
    end
    exp_q.delete(); pop_cyc_q.delete();
    model_last = N_CH - 1; pkt_cnt = 0; err_exp = 1'b0; hold_prev = 1'b0; rd_s = '0;
    refresh_inputs();
    ready_mode = 0;
    repeat (3) next_slot();
    rst_n = 1'b1;
    next_slot();
    clear_stamps();
    add_packet(3, 2);
    add_packet(0, 2);
    release_all();
    model_arbitrate();
    wait_drain(100, "post_rst");
    check("post_rst_count", acc_tid_q.size(), 4);
    if (acc_tid_q.size() == 4) check("post_rst_first_ch0", acc_tid_q[0], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cr_axi4s_mstr_arb.md
CR_AXI4S_MSTR_ARB -- requirements
Module: cr_axi4s_mstr_arb

Interface
REQ-001 Parameter N_CH, default 4: number of input channels, legal range 1..16.
REQ-002 Parameter DATA_W, default 64: tdata width in bits.
REQ-003 Parameter USER_W, default 8: tuser width in bits.
REQ-004 Parameter MAX_BEATS, default 256: maximum legal beats per packet.
REQ-005 Localparam CH_W = max(1, clog2(N_CH)).
REQ-006 clk  input  1  single clock; all logic rising-edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 in_empty  input  N_CH  per-channel show-ahead FIFO empty; head word valid when low.
REQ-009 in_data  input  N_CH*DATA_W  per-channel head tdata; channel i at [i*DATA_W +: DATA_W].
REQ-010 in_last  input  N_CH  per-channel head tlast.
REQ-011 in_user  input  N_CH*USER_W  per-channel head tuser.
REQ-012 in_rd  output  N_CH  per-channel pop strobe, one-hot or zero.
REQ-013 ob_tvalid  output  1  AXI4-Stream valid.
REQ-014 ob_tready  input  1  AXI4-Stream ready.
REQ-015 ob_tdata  output  DATA_W  AXI4-Stream data.
REQ-016 ob_tlast  output  1  AXI4-Stream last.
REQ-017 ob_tuser  output  USER_W  AXI4-Stream user.
REQ-018 ob_tid  output  CH_W  source channel of the current beat.
REQ-019 busy  output  1  high while a packet grant is held or the output buffer is non-empty.
REQ-020 err_oversize  output  1  sticky; set when a packet exceeds MAX_BEATS.
REQ-021 err_clr  input  1  synchronous clear of err_oversize.

Function
REQ-022 The FSM SHALL have two states. IDLE means no grant is held. XFER means the grant is locked to channel g.
REQ-023 IDLE: if any in_empty bit is low, the block SHALL select the first non-empty channel in the order rr_ptr+1, rr_ptr+2, ... (mod N_CH), register it as g, and move to XFER; it SHALL issue no pop in that cycle.
REQ-024 XFER: in_rd[g] = !in_empty[g] && occ<2; in_rd SHALL be 0 for all other channels. This path is combinational, with no dependency on ob_tready.
REQ-025 A pop with in_last[g]=1 SHALL return the FSM to IDLE on the next edge and set rr_ptr=g.
REQ-026 If channel g goes empty mid-packet, the block SHALL stall in XFER. The grant SHALL never switch before tlast is popped.
REQ-027 Output buffer: 2-entry FIFO, occupancy occ in 0..2. Per edge, occ_next = occ + pop - (ob_tvalid && ob_tready).
REQ-028 Each buffer entry SHALL hold {data, last, user, channel id}. ob_* SHALL present the oldest entry, and ob_tvalid = (occ != 0).
REQ-029 Latency: a word popped in cycle n SHALL be presented on ob_* at cycle n+1, provided it is oldest.
REQ-030 Sustained throughput SHALL be 1 beat/clk: occ=1 with a simultaneous pop and accept, in steady state.
REQ-031 While ob_tvalid=1 and ob_tready=0, all ob_* outputs SHALL hold stable (AXI rule).
REQ-032 Beat counter, width clog2(MAX_BEATS+1)+1: it SHALL increment on each pop and clear on a pop with last=1.
REQ-033 A pop that makes the beat count equal MAX_BEATS+1 SHALL set err_oversize. The data SHALL still be forwarded unmodified.
REQ-034 err_clr and a set event in the same cycle: set SHALL win.
REQ-035 N_CH=1: arbitration SHALL degenerate to channel 0, and ob_tid SHALL be 0.

Reset
REQ-036 On rst_n low, the following SHALL clear asynchronously:
- FSM = IDLE, occ = 0, rr_ptr = N_CH-1 (so channel 0 wins first), beat count = 0;
- err_oversize = 0;
- ob_tvalid/ob_tlast = 0, ob_tdata/ob_tuser/ob_tid = 0;
- in_rd = 0, busy = 0.
REQ-037 Reset asserted mid-packet SHALL discard buffered beats and the grant. After release, arbitration SHALL restart from channel 0, with no partial-packet resume.

Verification
REQ-038 All 4 channels hold a 2-beat packet at time 0, and ob_tready=1 -> packets emerge in ob_tid order 0,1,2,3; each tlast is on the 2nd beat; IDLE gaps are 1 cycle.
REQ-039 Channel 2 streams a 100-beat packet with ob_tready=1 -> 100 consecutive ob_tvalid cycles after the first; in_rd[2] is high every cycle; occ never reaches 2.
REQ-040 ob_tready toggles 1,0,0,1 during a packet -> occ rises to 2; in_rd stalls; ob_tdata is held during the 0 cycles; no beat is lost or duplicated (scoreboard).
REQ-041 Channel 1 goes empty at beat 3 of 5 while channel 0 is pending -> no switch; ob_tid stays 1 until its tlast; channel 0 is served next.
REQ-042 MAX_BEATS=4 and a 6-beat packet -> err_oversize rises after the 5th pop; all 6 beats are forwarded; err_clr=1 clears it the next cycle.
REQ-043 rst_n is pulsed low with occ=2 mid-packet on channel 3 -> all outputs zero immediately; after release, with channels 0 and 3 pending, channel 0 is granted first.
